tagger_lookup: RTL and testbench



---
 rtl/tagger_pkg.sv | 24 ++
 rtl/tagger_entry_match.sv | 55 +++++
 rtl/tagger_lookup.sv | 158 +++++++++++++++
 tb/tb_tagger_lookup.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tagger_pkg.sv
// -----------------------------------------------------------------------------
// tagger_pkg
// Shared definitions for the partition-tagging lookup path:
//   - TAB_ADDR_WIDTH : width of the table address field (34-bit physical space)
//   - TAG_OFF/TAG_TOR/TAG_NA4/TAG_NAPOT : PMP-style region encodings
//   - tag_tab_entry_t : default table entry layout {addr, patid, conf}
// -----------------------------------------------------------------------------
package tagger_pkg;

    localparam int TAB_ADDR_WIDTH = 34;
    localparam int TAG_PATID_LEN  = 8;

    localparam logic [1:0] TAG_OFF   = 2'b00;
    localparam logic [1:0] TAG_TOR   = 2'b01;
    localparam logic [1:0] TAG_NA4   = 2'b10;
    localparam logic [1:0] TAG_NAPOT = 2'b11;

    typedef struct packed {
        logic [TAB_ADDR_WIDTH-1:0] addr;
        logic [TAG_PATID_LEN-1:0]  patid;
        logic [1:0]                conf;
    } tag_tab_entry_t;

endpackage

// File: rtl/tagger_entry_match.sv
// -----------------------------------------------------------------------------
// tagger_entry_match
// Decides whether one partition-table entry covers a 34-bit address.
// Ports:
//   addr_i       : request address (low 34 bits)
//   entry_addr_i : this entry's addr field
//   lower_i      : TOR lower bound (previous entry's addr, or 0 for entry 0)
//   conf_i       : region encoding (OFF/TOR/NA4/NAPOT)
//   match_o      : 1 when the entry covers addr_i
// -----------------------------------------------------------------------------
module tagger_entry_match
    import tagger_pkg::*;
(
    input  logic [TAB_ADDR_WIDTH-1:0] addr_i,
    input  logic [TAB_ADDR_WIDTH-1:0] entry_addr_i,
    input  logic [TAB_ADDR_WIDTH-1:0] lower_i,
    input  logic [1:0]                conf_i,
    output logic                      match_o
);

    logic [TAB_ADDR_WIDTH-1:0] napot_mask;
    int                        trail;
    logic                      run;

    // NAPOT: count trailing ones of addr[33:2]; the region spans 2^(trail+3)
    // bytes, so the low trail+3 bits are don't-care. An all-ones field gives
    // trail=32 and an all-zero mask, i.e. the whole space.
    always_comb begin
        trail = 0;
        run   = 1'b1;
        for (int i = 2; i < TAB_ADDR_WIDTH; i++) begin
            if (run && entry_addr_i[i]) begin
                trail = trail + 1;
            end else begin
                run = 1'b0;
            end
        end
        for (int i = 0; i < TAB_ADDR_WIDTH; i++) begin
            napot_mask[i] = (i >= trail + 3);
        end
    end

    always_comb begin
        match_o = 1'b0;
        case (conf_i)
            TAG_OFF:   match_o = 1'b0;
            // An empty or inverted range (T <= L) falls out of the compare.
            TAG_TOR:   match_o = (lower_i <= addr_i) && (addr_i < entry_addr_i);
            TAG_NA4:   match_o = (addr_i[TAB_ADDR_WIDTH-1:2] == entry_addr_i[TAB_ADDR_WIDTH-1:2]);
            TAG_NAPOT: match_o = (((addr_i ^ entry_addr_i) & napot_mask) == '0);
            default:   match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/tagger_lookup.sv
// -----------------------------------------------------------------------------
// tagger_lookup
// Tags each memory request with the partition ID of the lowest-index table
// entry covering its address, registering the result for one cycle.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   tag_tab_i                : partition table (MAXPARTITION entries)
//   req_valid_i/req_ready_o  : request handshake
//   req_addr_i, req_payload_i: request address and opaque payload
//   out_valid_o/out_ready_i  : tagged-request handshake
//   out_addr_o, out_payload_o: registered request
//   out_patid_o, out_hit_o, out_idx_o : lookup result (DEFAULT_PATID/0/0 on miss)
//   miss_cnt_o               : saturating count of accepted misses
// -----------------------------------------------------------------------------
module tagger_lookup
    import tagger_pkg::*;
#(
    parameter int unsigned          MAXPARTITION   = 2,
    parameter int unsigned          PATID_LEN      = 8,
    parameter int unsigned          ADDR_WIDTH     = 64,
    parameter logic [PATID_LEN-1:0] DEFAULT_PATID  = '0,
    parameter int unsigned          MISS_CNT_WIDTH = 16,
    parameter type                  tag_tab_t      = tag_tab_entry_t,
    parameter type                  payload_t      = logic,
    localparam int unsigned         IDX_W          = (MAXPARTITION > 1) ? $clog2(MAXPARTITION) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  tag_tab_t [MAXPARTITION-1:0]  tag_tab_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_WIDTH-1:0]        req_addr_i,
    input  payload_t                     req_payload_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [ADDR_WIDTH-1:0]        out_addr_o,
    output payload_t                     out_payload_o,
    output logic [PATID_LEN-1:0]         out_patid_o,
    output logic                         out_hit_o,
    output logic [IDX_W-1:0]             out_idx_o,
    output logic [MISS_CNT_WIDTH-1:0]    miss_cnt_o
);

    logic [MAXPARTITION-1:0] entry_hit;
    logic [MAXPARTITION-1:0] entry_hit_masked;
    logic                    upper_ok;
    logic                    accept;

    logic                    win_hit;
    logic [IDX_W-1:0]        win_idx;
    logic [PATID_LEN-1:0]    win_patid;

    logic                      out_valid_q,   out_valid_d;
    logic [ADDR_WIDTH-1:0]     out_addr_q,    out_addr_d;
    payload_t                  out_payload_q, out_payload_d;
    logic [PATID_LEN-1:0]      out_patid_q,   out_patid_d;
    logic                      out_hit_q,     out_hit_d;
    logic [IDX_W-1:0]          out_idx_q,     out_idx_d;
    logic [MISS_CNT_WIDTH-1:0] miss_cnt_q,    miss_cnt_d;

    // Addresses above the 34-bit table space can never be covered.
    if (ADDR_WIDTH > TAB_ADDR_WIDTH) begin : g_upper
        assign upper_ok = ~|req_addr_i[ADDR_WIDTH-1:TAB_ADDR_WIDTH];
    end else begin : g_no_upper
        assign upper_ok = 1'b1;
    end

    for (genvar k = 0; k < MAXPARTITION; k++) begin : g_entry
        logic [TAB_ADDR_WIDTH-1:0] lower;
        // TOR lower bound is the previous entry's addr whatever its conf.
        if (k == 0) begin : g_first
            assign lower = '0;
        end else begin : g_rest
            assign lower = tag_tab_i[k-1].addr;
        end

        tagger_entry_match u_match (
            .addr_i       (req_addr_i[TAB_ADDR_WIDTH-1:0]),
            .entry_addr_i (tag_tab_i[k].addr),
            .lower_i      (lower),
            .conf_i       (tag_tab_i[k].conf),
            .match_o      (entry_hit[k])
        );
    end

    assign entry_hit_masked = entry_hit & {MAXPARTITION{upper_ok}};

    // Priority encoder: scan from the top so the lowest matching index
    // is the last one written and therefore wins.
    always_comb begin
        win_hit   = |entry_hit_masked;
        win_idx   = '0;
        win_patid = DEFAULT_PATID;
        for (int k = MAXPARTITION - 1; k >= 0; k--) begin
            if (entry_hit_masked[k]) begin
                win_idx   = IDX_W'(k);
                win_patid = PATID_LEN'(tag_tab_i[k].patid);
            end
        end
    end

    assign req_ready_o = !out_valid_q || out_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_addr_d    = out_addr_q;
        out_payload_d = out_payload_q;
        out_patid_d   = out_patid_q;
        out_hit_d     = out_hit_q;
        out_idx_d     = out_idx_q;
        miss_cnt_d    = miss_cnt_q;

        if (accept) begin
            // Accept overwrites the slot even when it drains this same cycle.
            out_valid_d   = 1'b1;
            out_addr_d    = req_addr_i;
            out_payload_d = req_payload_i;
            out_patid_d   = win_patid;
            out_hit_d     = win_hit;
            out_idx_d     = win_idx;
            if (!win_hit && !(&miss_cnt_q)) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q   <= 1'b0;
            out_addr_q    <= '0;
            out_payload_q <= payload_t'('0);
            out_patid_q   <= '0;
            out_hit_q     <= 1'b0;
            out_idx_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_payload_q <= out_payload_d;
            out_patid_q   <= out_patid_d;
            out_hit_q     <= out_hit_d;
            out_idx_q     <= out_idx_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_addr_o    = out_addr_q;
    assign out_payload_o = out_payload_q;
    assign out_patid_o   = out_patid_q;
    assign out_hit_o     = out_hit_q;
    assign out_idx_o     = out_idx_q;
    assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_tagger_lookup.sv
// -----------------------------------------------------------------------------
// tb_tagger_lookup
// Directed and randomized stimulus for tagger_lookup, checked against a
// cycle-level reference model that evaluates the region rules arithmetically.
// -----------------------------------------------------------------------------
module tb_tagger_lookup;
    import tagger_pkg::*;

    localparam int MAXP = 2;
    localparam int AW   = 64;
    localparam int PL   = 8;
    localparam int MW   = 2;
    localparam int MISS_MAX = (1 << MW) - 1;

    typedef logic [15:0] pay_t;

    logic                       clk;
    logic                       rst_n;
    tag_tab_entry_t [MAXP-1:0]  tab;
    logic                       req_valid;
    logic                       req_ready;
    logic [AW-1:0]              req_addr;
    pay_t                       req_payload;
    logic                       out_valid;
    logic                       out_ready;
    logic [AW-1:0]              out_addr;
    pay_t                       out_payload;
    logic [PL-1:0]              out_patid;
    logic                       out_hit;
    logic [0:0]                 out_idx;
    logic [MW-1:0]              miss_cnt;

    tagger_lookup #(
        .MAXPARTITION   (MAXP),
        .PATID_LEN      (PL),
        .ADDR_WIDTH     (AW),
        .DEFAULT_PATID  (8'h00),
        .MISS_CNT_WIDTH (MW),
        .tag_tab_t      (tag_tab_entry_t),
        .payload_t      (pay_t)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tag_tab_i     (tab),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_payload_i (req_payload),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_addr_o    (out_addr),
        .out_payload_o (out_payload),
        .out_patid_o   (out_patid),
        .out_hit_o     (out_hit),
        .out_idx_o     (out_idx),
        .miss_cnt_o    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the output slot should hold.
    logic          m_valid;
    logic [AW-1:0] m_addr;
    pay_t          m_pay;
    logic [PL-1:0] m_patid;
    logic          m_hit;
    int            m_idx;
    int            m_miss;
    logic          last_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Does entry k cover byte address a (already known to be < 2^34)?
    function automatic bit entry_covers(int k, longint unsigned a);
        longint unsigned t_addr, lo, size, base;
        int t;
        t_addr = 64'(tab[k].addr);
        lo     = (k == 0) ? 64'd0 : 64'(tab[k-1].addr);
        case (tab[k].conf)
            2'b01: return (a >= lo) && (a < t_addr);
            2'b10: return (a / 4) == (t_addr / 4);
            2'b11: begin
                t = 0;
                while (t < 32 && ((t_addr >> (t + 2)) & 64'd1) == 64'd1) t++;
                if (t == 32) return 1'b1;
                size = 64'd1 << (t + 3);
                base = (t_addr / size) * size;
                return (a >= base) && (a < base + size);
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic void ref_lookup(input logic [63:0] a, output logic hit,
                                       output int idx, output logic [PL-1:0] patid);
        hit = 1'b0; idx = 0; patid = 8'h00;
        if ((a >> 34) != 64'd0) return;
        for (int k = 0; k < MAXP; k++) begin
            if (!hit && entry_covers(k, 64'(a))) begin
                hit = 1'b1; idx = k; patid = tab[k].patid;
            end
        end
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_addr = '0; m_pay = '0; m_patid = '0;
        m_hit = 1'b0; m_idx = 0; m_miss = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},   64'(out_valid),   64'(m_valid));
        check({tag, ".addr"},    64'(out_addr),    64'(m_addr));
        check({tag, ".payload"}, 64'(out_payload), 64'(m_pay));
        check({tag, ".patid"},   64'(out_patid),   64'(m_patid));
        check({tag, ".hit"},     64'(out_hit),     64'(m_hit));
        check({tag, ".idx"},     64'(out_idx),     64'(m_idx));
        check({tag, ".miss"},    64'(miss_cnt),    64'(m_miss));
    endtask

    // One clock: inputs are already driven; check ready, clock, update model, check slot.
    task automatic cycle(input string tag);
        logic exp_ready;
        logic h;
        int i;
        logic [PL-1:0] p;
        #1;
        exp_ready = !m_valid || out_ready;
        check({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        last_acc = req_valid && exp_ready;
        if (last_acc) begin
            ref_lookup(req_addr, h, i, p);
            m_valid = 1'b1; m_addr = req_addr; m_pay = req_payload;
            m_patid = p; m_hit = h; m_idx = i;
            if (!h && m_miss < MISS_MAX) m_miss++;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic send(input logic [63:0] a, input pay_t p, input string tag);
        req_valid = 1'b1; req_addr = a; req_payload = p;
        cycle(tag);
    endtask

    logic [63:0] bp_q[$];

    initial begin
        tab = '0;
        req_valid = 1'b0; req_addr = '0; req_payload = '0; out_ready = 1'b1;
        last_acc = 1'b0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // NAPOT entry covering 0x0..0x1FFF
        tab[0].addr = 34'h3FF << 2; tab[0].patid = 8'h11; tab[0].conf = TAG_NAPOT;
        send(64'h1000, 16'hA001, "napot_hit");
        check("napot_hit.patid_const", 64'(out_patid), 64'h11);
        send(64'h2000, 16'hA002, "napot_miss");
        check("napot_miss.cnt_const", 64'(miss_cnt), 64'd1);

        // TOR entry [0xFFC, 0x4000) behind the NAPOT entry
        tab[1].addr = 34'h4000; tab[1].patid = 8'h22; tab[1].conf = TAG_TOR;
        send(64'h3000, 16'hB001, "tor_hit");
        check("tor_hit.idx_const", 64'(out_idx), 64'd1);
        send(64'h1000, 16'hB002, "prio");
        check("prio.patid_const", 64'(out_patid), 64'h11);
        send(64'h4000, 16'hB003, "tor_top");
        send(64'h4_0000_1000, 16'hB004, "upper_bits");
        check("upper_bits.hit_const", 64'(out_hit), 64'd0);
        send(64'h5000, 16'hB005, "sat1");
        send(64'h6000, 16'hB006, "sat2");
        check("sat.cnt_const", 64'(miss_cnt), 64'd3);
        req_valid = 1'b0;
        cycle("idle");

        // Backpressure: stall 5 cycles, then drain with preserved order
        bp_q = '{64'h1000, 64'h3000, 64'h7000, 64'h0FFC, 64'h2FF8};
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1; req_addr = bp_q[0]; req_payload = 16'hC000 + 16'(bp_q.size());
            cycle("bp_stall");
            if (last_acc) void'(bp_q.pop_front());
        end
        check("bp_stall.ready_const", 64'(req_ready), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && bp_q.size() > 0; c++) begin
            req_valid = 1'b1; req_addr = bp_q[0]; req_payload = 16'hC000 + 16'(bp_q.size());
            cycle("bp_drain");
            if (last_acc) void'(bp_q.pop_front());
        end
        check("bp_drain.empty", 64'(bp_q.size()), 64'd0);
        req_valid = 1'b0;
        cycle("bp_idle");

        // Table change while a request is held in the slot
        send(64'h3000, 16'hD001, "inflight_acc");
        req_valid = 1'b0; out_ready = 1'b0;
        tab[1].patid = 8'h33;
        cycle("inflight_hold");
        check("inflight.patid_const", 64'(out_patid), 64'h22);
        out_ready = 1'b1;
        cycle("inflight_drain");
        send(64'h3000, 16'hD002, "inflight_new");
        check("inflight_new.patid_const", 64'(out_patid), 64'h33);

        // Asynchronous reset while a request is held
        out_ready = 1'b0;
        send(64'h2000, 16'hE001, "prereset");
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        cycle("post_reset");

        // Randomized traffic and tables
        for (int n = 0; n < 400; n++) begin
            if (n % 40 == 0) begin
                for (int k = 0; k < MAXP; k++) begin
                    tab[k].conf  = 2'($urandom_range(0, 3));
                    tab[k].patid = 8'($urandom);
                    if ($urandom_range(0, 9) == 0) tab[k].addr = 34'h3_FFFF_FFFF;
                    else tab[k].addr = 34'($urandom_range(0, 16'hFFFF));
                end
            end
            req_valid   = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            req_payload = 16'($urandom);
            if ($urandom_range(0, 15) == 0) req_addr = {$urandom, $urandom};
            else req_addr = 64'($urandom_range(0, 16'hFFFF));
            cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
